mc_ctrl: RTL

- Multi-cycle control sequencer for the MIPS core: owns the state machine that drives next-PC select (`Br`, `jump`), PC/IR/GRF write enables and memory requests. It is the block that decides when and how the next-PC logic commits.
- Each instruction walks IF/ID/EXE/MEM/WB as needed. The PC is written exactly once, in the instruction's last state, so the next-PC logic always sees the instruction's own PC.
- Instruction and data memories are variable-latency, using req/ready handshakes.

---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/mc_ctrl_decode.sv | 32 +++
 rtl/mc_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, next-PC
// selects, opcode/funct codes, datapath select codes and the decoded instruction class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [2:0] BR_pc4 = 3'd0;
    localparam logic [2:0] BR_j   = 3'd1;
    localparam logic [2:0] BR_jr  = 3'd2;
    localparam logic [2:0] BR_beq = 3'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] A3_RT  = 2'd0;
    localparam logic [1:0] A3_RD  = 2'd1;
    localparam logic [1:0] A3_RA  = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    // One-hot instruction class produced by mc_decode.
    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
                    FN_JR:            cls.jr        = 1'b1;
                    FN_SLL:           cls.nop       = 1'b1;
                    default:          cls.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: IF/ID/EXE/MEM/WB walk, next-PC commit control,
// memory handshakes and a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_we,
    output logic                pc_we,
    output logic [2:0]          br_sel,
    output logic                jump,
    output logic                reg_we,
    output logic [1:0]          a3_sel,
    output logic [1:0]          wd_sel,
    output logic [2:0]          alu_op,
    output logic                alu_bsel,
    output logic                ext_op,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state_o
);

    state_t              state_reg, state_next;
    logic [RETIRE_W-1:0] retired_reg;
    iclass_t             cls;
    logic [2:0]          alu_op_c;
    logic                alu_bsel_c, ext_op_c;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_INIT;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pc_we)
                retired_reg <= retired_reg + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    // ALU controls stay valid through MEM/WB because the ALU result is not registered.
    always_comb begin
        alu_op_c   = ALU_ADD;
        alu_bsel_c = 1'b0;
        ext_op_c   = 1'b0;
        if (cls.rtype_alu)
            alu_op_c = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        if (cls.beq)
            alu_op_c = ALU_SUB;
        if (cls.ori) begin
            alu_op_c   = ALU_OR;
            alu_bsel_c = 1'b1;
        end
        if (cls.lui) begin
            alu_op_c   = ALU_LUI;
            alu_bsel_c = 1'b1;
        end
        if (cls.lw || cls.sw) begin
            alu_bsel_c = 1'b1;
            ext_op_c   = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        br_sel     = BR_pc4;
        jump       = 1'b0;
        reg_we     = 1'b0;
        a3_sel     = A3_RT;
        wd_sel     = WD_ALU;
        alu_op     = ALU_ADD;
        alu_bsel   = 1'b0;
        ext_op     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;
        if (state_reg == S_EXE || state_reg == S_MEM || state_reg == S_WB) begin
            alu_op   = alu_op_c;
            alu_bsel = alu_bsel_c;
            ext_op   = ext_op_c;
        end
        case (state_reg)
            S_INIT: state_next = S_IF;
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_ID;
                end
            end
            S_ID: begin
                if (cls.j) begin
                    pc_we      = 1'b1;
                    br_sel     = BR_j;
                    state_next = S_IF;
                end else if (cls.jr) begin
                    pc_we      = 1'b1;
                    br_sel     = BR_jr;
                    state_next = S_IF;
                end else if (cls.jal) begin
                    state_next = S_WB;
                end else if (cls.rtype_alu || cls.ori || cls.lui || cls.lw || cls.sw || cls.beq) begin
                    state_next = S_EXE;
                end else begin
                    pc_we      = 1'b1;
                    illegal    = cls.illegal & ~cls.nop;
                    state_next = S_IF;
                end
            end
            S_EXE: begin
                if (cls.beq) begin
                    // Commit unconditionally; jump lets the next-PC logic pick target or pc+4.
                    pc_we      = 1'b1;
                    br_sel     = BR_beq;
                    jump       = zero;
                    state_next = S_IF;
                end else if (cls.lw || cls.sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.sw;
                if (dmem_ready) begin
                    if (cls.sw) begin
                        pc_we      = 1'b1;
                        state_next = S_IF;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                state_next = S_IF;
                if (cls.jal) begin
                    a3_sel = A3_RA;
                    wd_sel = WD_PC4;
                    br_sel = BR_j;
                end else if (cls.lw) begin
                    wd_sel = WD_DM;
                end else if (cls.rtype_alu) begin
                    a3_sel = A3_RD;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    assign retired = retired_reg;
    assign state_o = state_reg;

endmodule
